axi_sram_slave: RTL and testbench

//  AXI3-style slave (responder) backed by an internal byte-writable SRAM; the counterpart of the
//  CPU-side SRAM-to-AXI master bridge. Used as simulation main memory and on-chip RAM behind the core.

---
 rtl/axi_pkg.sv | 18 +
 rtl/axi_slv_sram_1rw.sv | 29 ++
 rtl/axi_sram_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response/burst codes, FSM encodings
// and the LFSR step used by the optional handshake-delay build.
package axi_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    typedef enum logic [1:0] {R_IDLE, R_RD, R_RESP} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_WRITE, W_RESP} w_state_t;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
endpackage

// File: rtl/axi_slv_sram_1rw.sv
// Single-port 32-bit synchronous SRAM, byte write enables, 1-cycle read latency.
// A write in the same cycle as a read wins; the read output register then holds.
module axi_slv_sram_1rw #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < 4; b++)
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    // Output register is only reloaded by a real read, so it stays stable during R stalls
    always_ff @(posedge clk) begin
        if (reset)          rdata <= '0;
        else if (re && !we) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave over a byte-writable SRAM: one INCR read burst plus one single-beat write in flight.
// Define AXI_SLV_RAND_DELAY_EN to gate ready/valid with a free-running LFSR. Memory contents power up undefined.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    r_state_t            r_state, r_nxt;
    w_state_t            w_state, w_nxt;
    logic [3:0]          r_id, r_len, r_cnt, w_id, w_strb;
    logic [MEM_AW-1:0]   r_addr, w_addr;
    logic [31:0]         w_data;
    logic                r_err, w_err;
    logic                g_ar, g_aw, g_w, r_gate, b_gate;
    logic                sram_re, sram_we, rd_stall;
    logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;

    logic unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, awsize, awburst,
                         wid, wlast, arlen[7:4], araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0]};

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic        r_vis, b_vis;
    // r_vis/b_vis keep a raised valid up until its handshake, whatever the LFSR does
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr  <= 16'hACE1;
            r_vis <= 1'b0;
            b_vis <= 1'b0;
        end else begin
            lfsr  <= lfsr_next(lfsr);
            r_vis <= rvalid & ~rready;
            b_vis <= bvalid & ~bready;
        end
    end
    assign g_ar   = lfsr[0];
    assign g_aw   = lfsr[1];
    assign g_w    = lfsr[2];
    assign r_gate = lfsr[3] | r_vis;
    assign b_gate = lfsr[4] | b_vis;
`else
    assign g_ar   = 1'b1;
    assign g_aw   = 1'b1;
    assign g_w    = 1'b1;
    assign r_gate = 1'b1;
    assign b_gate = 1'b1;
`endif

    assign ar_hs    = arvalid & arready;
    assign r_hs     = rvalid & rready;
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign b_hs     = bvalid & bready;
    assign rd_stall = (w_state == W_WRITE);
    assign sram_we  = (w_state == W_WRITE) & ~w_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_nxt;
            w_state <= w_nxt;
        end
    end

    always_comb begin
        r_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_nxt = R_RD;
            R_RD:    if (!rd_stall) r_nxt = R_RESP;
            R_RESP:  if (r_hs) r_nxt = (r_cnt == r_len) ? R_IDLE : R_RD;
            default: r_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        sram_re = 1'b0;
        case (r_state)
            R_IDLE:  arready = g_ar;
            R_RD:    sram_re = ~rd_stall;
            R_RESP: begin
                rvalid = r_gate;
                rlast  = (r_cnt == r_len);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_nxt = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_nxt = W_WRITE;
                else if (aw_hs)    w_nxt = W_HAVE_AW;
                else if (w_hs)     w_nxt = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  w_nxt = W_WRITE;
            W_HAVE_W:  if (aw_hs) w_nxt = W_WRITE;
            W_WRITE:   w_nxt = W_RESP;
            W_RESP:    if (b_hs)  w_nxt = W_IDLE;
            default:   w_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = g_aw;
                wready  = g_w;
            end
            W_HAVE_AW: wready  = g_w;
            W_HAVE_W:  awready = g_aw;
            W_RESP:    bvalid  = b_gate;
            default: ;
        endcase
    end

    // Unsupported burst type/size still walks words upward but flags every beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id   <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_addr <= '0;
            r_err  <= 1'b0;
        end else if (ar_hs) begin
            r_id   <= arid;
            r_len  <= arlen[3:0];
            r_cnt  <= '0;
            r_addr <= araddr[MEM_AW+1:2];
            r_err  <= (arburst != BURST_INCR) || (arsize != SIZE_WORD);
        end else if (r_hs && r_cnt != r_len) begin
            r_cnt  <= r_cnt + 4'd1;
            r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_id   <= '0;
            w_addr <= '0;
            w_err  <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else begin
            if (aw_hs) begin
                w_id   <= awid;
                w_addr <= awaddr[MEM_AW+1:2];
                w_err  <= (awlen != 8'd0);
            end
            if (w_hs) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
        end
    end

    assign rid   = r_id;
    assign rresp = r_err ? RESP_SLVERR : RESP_OKAY;
    assign bid   = w_id;
    assign bresp = w_err ? RESP_SLVERR : RESP_OKAY;

    axi_slv_sram_1rw #(.AW(MEM_AW)) u_sram (
        .clk   (clk),
        .reset (reset),
        .re    (sram_re),
        .raddr (r_addr),
        .we    (sram_we),
        .waddr (w_addr),
        .wbe   (w_strb),
        .wdata (w_data),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (MEM_AW=14): latency, byte strobes, wrapping burst with
// rready stalls, write/read SRAM conflict, error responses and reset while responses pend.
module tb_axi_sram_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [16];

    always #5 clk = ~clk;

    axi_sram_slave #(.MEM_AW(14)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first
    task automatic wr(input int order, input logic [3:0] id, input logic [31:0] addr,
                      input logic [7:0] len, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] exp_resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int n = 0;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; wdata = data; wstrb = strb;
        awvalid = (order != 1);
        wvalid  = (order != 2);
        while (!(aw_done && w_done) && n < 20) begin
            hs_aw = awvalid & awready;
            hs_w  = wvalid & wready;
            @(negedge clk);
            n++;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin wvalid = 1'b0;  w_done = 1;  end
            if (aw_done && !w_done) wvalid = 1'b1;
            if (w_done && !aw_done) awvalid = 1'b1;
        end
        chk("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input bit toggle, input logic [1:0] exp_resp);
        int beat = 0, n = 0;
        bit held = 0;
        logic [31:0] hold_d = '0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (beat <= int'(len) && n < 100) begin
            rready = toggle ? n[1] : 1'b1;
            if (rvalid) begin
                if (held) chk("r_stable", rdata, hold_d);
                if (rready) begin
                    chk("rdata", rdata, exp_q[beat]);
                    chk("rid", rid, id);
                    chk("rlast", rlast, (beat == int'(len)));
                    chk("rresp", rresp, exp_resp);
                    beat++;
                    held = 0;
                end else begin
                    held = 1;
                    hold_d = rdata;
                end
            end
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        chk("rd_beats", beat, int'(len) + 1);
    endtask

    initial begin
        reset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        arlock = 0; arcache = 0; arprot = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        awlock = 0; awcache = 0; awprot = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 1; wvalid = 0; bready = 0;
        repeat (3) @(negedge clk);
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_ids", {rid, bid}, 0);
        chk("rst_resps", {rresp, bresp}, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1'b0;

        // Preload word 0x40, then single read with latency check
        wr(0, 4'd2, 32'h100, 8'd0, 32'h12345678, 4'hF, 2'b00);
        @(negedge clk);
        arid = 4'd1; araddr = 32'h100; arlen = 0; arburst = 2'b01; arvalid = 1'b1;
        chk("lat_arready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("lat_t1_rvalid", rvalid, 0);
        @(negedge clk);
        chk("lat_t2_rvalid", rvalid, 1);
        chk("lat_rdata", rdata, 32'h12345678);
        chk("lat_rid", rid, 1);
        chk("lat_rlast", rlast, 1);
        chk("lat_rresp", rresp, 0);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("lat_done", rvalid, 0);

        // Byte strobes, W channel ahead of AW
        wr(2, 4'd3, 32'h8, 8'd0, 32'h11223344, 4'hF, 2'b00);
        wr(1, 4'd1, 32'h8, 8'd0, 32'hAABBCCDD, 4'b0101, 2'b00);
        exp_q[0] = 32'h11BB33DD;
        rd(4'd2, 32'h8, 8'd0, 2'b01, 1'b0, 2'b00);

        // Burst wrapping the top of a 2^14-word space with rready stalls
        wr(0, 4'd4, 32'hFFFC, 8'd0, 32'hA0A0A0A0, 4'hF, 2'b00);
        wr(0, 4'd4, 32'h0,    8'd0, 32'hA1A1A1A1, 4'hF, 2'b00);
        wr(0, 4'd4, 32'h4,    8'd0, 32'hA2A2A2A2, 4'hF, 2'b00);
        exp_q[0] = 32'hA0A0A0A0; exp_q[1] = 32'hA1A1A1A1;
        exp_q[2] = 32'hA2A2A2A2; exp_q[3] = 32'h11BB33DD;
        rd(4'd3, 32'hFFFC, 8'd3, 2'b01, 1'b1, 2'b00);

        // SRAM write and read collide: read waits a cycle and sees new data
        wr(0, 4'd5, 32'h20, 8'd0, 32'h0, 4'hF, 2'b00);
        @(negedge clk);
        awid = 4'd6; awaddr = 32'h20; awlen = 0; wdata = 32'h5; wstrb = 4'hF;
        arid = 4'd7; araddr = 32'h20; arlen = 0; arburst = 2'b01;
        chk("cf_ready", {arready, awready, wready}, 3'b111);
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("cf_rvalid_t1", rvalid, 0);
        @(negedge clk);
        chk("cf_rvalid_stall", rvalid, 0);
        chk("cf_bvalid", bvalid, 1);
        @(negedge clk);
        chk("cf_rvalid", rvalid, 1);
        chk("cf_rdata", rdata, 32'h5);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;

        // Error responses: multi-beat write is refused, FIXED burst flagged but served
        wr(0, 4'd8, 32'h20, 8'd1, 32'hDEADBEEF, 4'hF, 2'b10);
        exp_q[0] = 32'h5;
        rd(4'd9, 32'h20, 8'd0, 2'b01, 1'b0, 2'b00);
        exp_q[0] = 32'hA1A1A1A1; exp_q[1] = 32'hA2A2A2A2;
        rd(4'd10, 32'h0, 8'd1, 2'b00, 1'b0, 2'b10);

        // Reset with both responses pending
        @(negedge clk);
        arid = 4'd11; araddr = 32'h20; arlen = 0; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'd12; awaddr = 32'h24; awlen = 0; wdata = 32'h9; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pend_rvalid", rvalid, 1);
        chk("pend_bvalid", bvalid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_arready", arready, 1);
        chk("mid_rst_awready", awready, 1);
        reset = 1'b0;
        exp_q[0] = 32'h5;
        rd(4'd13, 32'h20, 8'd0, 2'b01, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
